// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: the opcode and memory ready flag coming in, plus every
// mux select, write strobe and status flag going out.
interface multicycle_control_if;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal_op
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction, extended one cycle per mem_ready=0
// in FETCH/MEM_RD/MEM_WR. Outputs decode the state register, gated to zero while rst is high.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BEQ       = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e state_q, state_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BEQ only needs the compare.
        alu_src_b = 2'b11;
        case (bus.instr_op)
          OP_R:         state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.instr_op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ILLEGAL: begin
        // PC was already advanced in FETCH, so returning skips the instruction.
        illegal_op = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset overrides every output so no strobe escapes in the reset cycle.
  assign bus.pc_write      = ~rst & pc_write;
  assign bus.pc_write_cond = ~rst & pc_write_cond;
  assign bus.pc_source     = rst ? 2'b00 : pc_source;
  assign bus.iord          = ~rst & iord;
  assign bus.mem_read      = ~rst & mem_read;
  assign bus.mem_write     = ~rst & mem_write;
  assign bus.ir_write      = ~rst & ir_write;
  assign bus.reg_dst       = ~rst & reg_dst;
  assign bus.mem_to_reg    = ~rst & mem_to_reg;
  assign bus.reg_write     = ~rst & reg_write;
  assign bus.alu_src_a     = ~rst & alu_src_a;
  assign bus.alu_src_b     = rst ? 2'b00 : alu_src_b;
  assign bus.alu_op        = rst ? 2'b00 : alu_op;
  assign bus.state         = rst ? 4'd0 : state_q;
  assign bus.instr_done    = ~rst & instr_done;
  assign bus.illegal_op    = ~rst & illegal_op;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected outputs queued from a spec table
// and compared against the DUT, plus per-instruction instr_done/illegal_op counts.
module tb_multicycle_control;
  logic clk;
  logic rst;
  multicycle_control_if bus();

  multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] JUNK    = 6'b010101;

  out_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   ill_cnt  = 0;

  function automatic out_t exp_out(input logic [3:0] st, input logic rdy, input logic r);
    out_t o;
    o = '0;
    if (r) return o;
    o.state = st;
    case (st)
      4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      4'd1:  o.alu_src_b = 2'b11;
      4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.mem_read = 1; o.iord = 1; end
      4'd4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
      4'd5:  begin o.mem_write = 1; o.iord = 1; o.instr_done = rdy; end
      4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd7:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
      4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                   o.pc_source = 2'b01; o.instr_done = 1; end
      4'd9:  begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
      4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd11: begin o.reg_write = 1; o.instr_done = 1; end
      4'd12: o.illegal_op = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // One clock cycle: drive inputs at the falling edge, then compare outputs 1ns later.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic r,
                     input logic [3:0] st, input string tag);
    out_t got, exp;
    @(negedge clk);
    bus.instr_op  = op;
    bus.mem_ready = rdy;
    rst           = r;
    sb.push_back(exp_out(st, rdy, r));
    #1;
    got = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord,
           bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
           bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_done,
           bus.illegal_op};
    exp = sb.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    if (got.instr_done === 1'b1) done_cnt++;
    if (got.illegal_op === 1'b1) ill_cnt++;
  endtask

  task automatic end_instr(input string tag, input int exp_done, input int exp_ill);
    checks++;
    assert (done_cnt == exp_done && ill_cnt == exp_ill) else begin
      failures++;
      $error("FAIL %s pulses observed done=%0d illegal=%0d expected done=%0d illegal=%0d",
             tag, done_cnt, ill_cnt, exp_done, exp_ill);
    end
    done_cnt = 0;
    ill_cnt  = 0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.instr_op  = JUNK;
    bus.mem_ready = 1'b0;

    cyc(JUNK, 0, 1, 0, "reset_0");
    cyc(JUNK, 1, 1, 0, "reset_1");
    done_cnt = 0;
    ill_cnt  = 0;

    // Zero-wait sequence; opcode is junk outside DECODE/MEM_ADDR.
    cyc(JUNK,    1, 0, 0,  "r_fetch");   cyc(OP_R,    1, 0, 1,  "r_decode");
    cyc(JUNK,    1, 0, 6,  "r_exec");    cyc(JUNK,    1, 0, 7,  "r_wb");
    end_instr("r_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "addi_fetch"); cyc(OP_ADDI, 1, 0, 1,  "addi_decode");
    cyc(JUNK,    1, 0, 10, "addi_exec");  cyc(JUNK,    1, 0, 11, "addi_wb");
    end_instr("addi_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "lw_fetch");  cyc(OP_LW,   1, 0, 1,  "lw_decode");
    cyc(OP_LW,   1, 0, 2,  "lw_addr");   cyc(JUNK,    1, 0, 3,  "lw_rd");
    cyc(JUNK,    1, 0, 4,  "lw_wb");
    end_instr("lw_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "sw_fetch");  cyc(OP_SW,   1, 0, 1,  "sw_decode");
    cyc(OP_SW,   1, 0, 2,  "sw_addr");   cyc(JUNK,    1, 0, 5,  "sw_wr");
    end_instr("sw_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "beq_fetch"); cyc(OP_BEQ,  1, 0, 1,  "beq_decode");
    cyc(JUNK,    1, 0, 8,  "beq_exec");
    end_instr("beq_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "j_fetch");   cyc(OP_J,    1, 0, 1,  "j_decode");
    cyc(JUNK,    1, 0, 9,  "j_exec");
    end_instr("j_pulses", 1, 0);

    // mem_ready low outside memory states must not stall.
    cyc(JUNK,    1, 0, 0,  "r2_fetch");  cyc(OP_R,    0, 0, 1,  "r2_decode");
    cyc(JUNK,    0, 0, 6,  "r2_exec");   cyc(JUNK,    0, 0, 7,  "r2_wb");
    end_instr("r2_pulses", 1, 0);

    // lw: 2 waits in FETCH, 3 in MEM_RD -> 10 cycles.
    cyc(JUNK,    0, 0, 0,  "lww_fetch_w0"); cyc(JUNK, 0, 0, 0, "lww_fetch_w1");
    cyc(JUNK,    1, 0, 0,  "lww_fetch_rdy");
    cyc(OP_LW,   0, 0, 1,  "lww_decode");   cyc(OP_LW, 0, 0, 2, "lww_addr");
    cyc(JUNK,    0, 0, 3,  "lww_rd_w0");    cyc(JUNK, 0, 0, 3, "lww_rd_w1");
    cyc(JUNK,    0, 0, 3,  "lww_rd_w2");    cyc(JUNK, 1, 0, 3, "lww_rd_rdy");
    cyc(JUNK,    0, 0, 4,  "lww_wb");
    end_instr("lww_pulses", 1, 0);

    // sw with a single write wait.
    cyc(JUNK,    1, 0, 0,  "sww_fetch");  cyc(OP_SW, 1, 0, 1, "sww_decode");
    cyc(OP_SW,   1, 0, 2,  "sww_addr");   cyc(JUNK,  0, 0, 5, "sww_wr_w0");
    cyc(JUNK,    1, 0, 5,  "sww_wr_rdy");
    end_instr("sww_pulses", 1, 0);

    // Unsupported opcode.
    cyc(OP_BAD,  1, 0, 0,  "ill_fetch");  cyc(OP_BAD, 1, 0, 1, "ill_decode");
    cyc(OP_BAD,  1, 0, 12, "ill_state");
    end_instr("ill_pulses", 0, 1);

    // Reset during a MEM_RD wait aborts the load without a register write.
    cyc(JUNK,    1, 0, 0,  "rst_fetch");  cyc(OP_LW, 1, 0, 1, "rst_decode");
    cyc(OP_LW,   1, 0, 2,  "rst_addr");   cyc(JUNK,  0, 0, 3, "rst_rd_wait");
    cyc(JUNK,    0, 1, 0,  "rst_midwait");
    cyc(JUNK,    1, 0, 0,  "rst_after_fetch");
    cyc(OP_J,    1, 0, 1,  "rst_after_decode");
    cyc(JUNK,    1, 0, 9,  "rst_after_jump");
    end_instr("rst_pulses", 1, 0);
    cyc(JUNK,    1, 0, 0,  "final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
